// File: rtl/tx_cmd_scheduler.sv
// Round-robin arbiter that shares one UART byte transmitter among NUM_REQ command sources,
// with a launch timeout and a minimum idle gap between bytes.
module tx_cmd_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_CYCLES = 100000,
  parameter int unsigned BUSY_TMO   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_err
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (GAP_CYCLES > BUSY_TMO) ? GAP_CYCLES : BUSY_TMO;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(BUSY_TMO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    last_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [NUM_REQ-1:0] ready_nx;
  logic [7:0]         data_nx;
  logic               start_nx;
  logic [ID_W-1:0]    id_nx;
  logic               err_nx;
  logic [ID_W-1:0]    win;
  logic               win_vld;
  logic [7:0]         data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[8*g +: 8];
  end

  // First valid requester after the last one granted, wrapping around
  always_comb begin
    win     = last_grant;
    win_vld = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld && req_valid[ID_W'((32'(last_grant) + k) % NUM_REQ)]) begin
        win     = ID_W'((32'(last_grant) + k) % NUM_REQ);
        win_vld = 1'b1;
      end
    end
  end

  // State and registered outputs; one shared counter serves both timeout and gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= '0;
      tx_start   <= 1'b0;
      tx_err     <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= LAST_INIT;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      req_ready  <= ready_nx;
      tx_start   <= start_nx;
      tx_err     <= err_nx;
      tx_data    <= data_nx;
      grant_id   <= id_nx;
      last_grant <= last_nx;
      cnt        <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (win_vld) state_nx = LAUNCH;
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)              state_nx = WAIT_DONE;
        else if (cnt == TMO_LAST) state_nx = GAP;
      end
      WAIT_DONE: if (!tx_busy) state_nx = GAP;
      GAP:       if (cnt == GAP_LAST) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready_nx = '0;
    start_nx = 1'b0;
    err_nx   = 1'b0;
    data_nx  = tx_data;
    id_nx    = grant_id;
    last_nx  = last_grant;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          ready_nx[win] = 1'b1;
          start_nx      = 1'b1;
          data_nx       = data_arr[win];
          id_nx         = win;
          last_nx       = win;
        end
      end
      LAUNCH:    cnt_nx = '0;
      WAIT_BUSY: begin
        if (!tx_busy) begin
          if (cnt == TMO_LAST) begin
            err_nx = 1'b1;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      // Held at zero so the gap always starts counting from 0
      WAIT_DONE: cnt_nx = '0;
      GAP:       cnt_nx = (cnt == GAP_LAST) ? '0 : cnt + CNT_W'(1);
      default:   cnt_nx = '0;
    endcase
  end

endmodule

// File: tb/tb_tx_cmd_scheduler.sv
// Bench for tx_cmd_scheduler: directed scenarios plus randomized traffic checked against a
// round-robin/timing reference model (GAP_CYCLES=20, BUSY_TMO=16).
module tb_tx_cmd_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int          GAP     = 20;
  localparam int          TMO     = 16;
  localparam int          BUDGET  = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        tx_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cnt = 0;
  int err_cnt   = 0;
  int r1_cnt    = 0;
  int mdl_last;

  tx_cmd_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .GAP_CYCLES(GAP),
    .BUSY_TMO  (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .tx_err   (tx_err)
  );

  always #5 clk = ~clk;

  // Cycle count and pulse counters (each edge counts the value held in the cycle just ended)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start)     start_cnt <= start_cnt + 1;
    if (tx_err)       err_cnt   <= err_cnt + 1;
    if (req_ready[1]) r1_cnt    <= r1_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data = (req_data & ~(32'hFF << (8 * i))) | (32'(b) << (8 * i));
  endtask

  function automatic logic [7:0] get_byte(input int i);
    return 8'(req_data >> (8 * i));
  endfunction

  // Reference arbitration rule: first valid index after the last grant, modulo NUM_REQ
  function automatic int rr_pick(input int last, input logic [3:0] mask);
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (((mask >> ((last + k) % NUM_REQ)) & 4'd1) != 4'd0) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    mdl_last = NUM_REQ - 1;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_err(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (tx_err) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Called in the tx_start cycle: UART goes busy d cycles later and stays busy len cycles
  task automatic uart_frame(input int d, input int len);
    repeat (d) tick();
    tx_busy = 1'b1;
    repeat (len) tick();
    tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int t0;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h44332211;
    tx_busy   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({req_ready, tx_start, tx_err, tx_data, grant_id} !== 16'h0) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got ready=%b start=%b err=%b data=%h id=%0d want all 0",
                 i, req_ready, tx_start, tx_err, tx_data, grant_id);
      end
    end
    rst = 1'b0;
    mdl_last = NUM_REQ - 1;
    t0 = cyc;
    wait_start(BUDGET, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_first_start: got no tx_start want one"); end
    total++;
    if (cyc - t0 != 1) begin bad++; $display("FAIL reset_latency: got %0d want 1", cyc - t0); end
    total++;
    if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_first_grant: got %0d want 0", grant_id); end
    total++;
    if (tx_data !== 8'h11) begin bad++; $display("FAIL reset_first_data: got %h want 11", tx_data); end
    req_valid = 4'h0;
    uart_frame(2, 4);
  endtask

  task automatic test_single();
    bit ok;
    apply_reset(2);
    req_data = 32'h0;
    set_byte(2, 8'h2F);
    req_valid = 4'b0100;
    wait_start(BUDGET, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_start: got no tx_start want one"); end
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    total++;
    if (tx_data !== 8'h2F) begin bad++; $display("FAIL single_data: got %h want 2f", tx_data); end
    total++;
    if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    req_valid = 4'h0;
    tick();
    total++;
    if ({tx_start, req_ready} !== 5'b0) begin
      bad++;
      $display("FAIL single_pulse_width: got start=%b ready=%b want 0/0000", tx_start, req_ready);
    end
    tick();
    tx_busy = 1'b1;
    repeat (10) tick();
    tx_busy = 1'b0;
    tick();
    total++;
    if (tx_data !== 8'h2F || tx_err !== 1'b0) begin
      bad++;
      $display("FAIL single_hold: got data=%h err=%b want 2f/0", tx_data, tx_err);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int w;
    int fall_cyc;
    apply_reset(2);
    for (int i = 0; i < int'(NUM_REQ); i++) set_byte(i, 8'(8'hA0 + i));
    req_valid = 4'hF;
    fall_cyc  = 0;
    for (int n = 0; n < 5; n++) begin
      wait_start(BUDGET, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rr_start[%0d]: got no tx_start want one", n); end
      w = rr_pick(mdl_last, req_valid);
      mdl_last = w;
      total++;
      if (grant_id !== 2'(w)) begin bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", n, grant_id, w); end
      total++;
      if (tx_data !== get_byte(w)) begin
        bad++;
        $display("FAIL rr_data[%0d]: got %h want %h", n, tx_data, get_byte(w));
      end
      // Gap of GAP cycles, one IDLE sampling edge, then the launch edge
      if (n > 0) begin
        total++;
        if (cyc != fall_cyc + GAP + 2) begin
          bad++;
          $display("FAIL rr_gap[%0d]: got start %0d cycles after busy fell want %0d", n, cyc - fall_cyc, GAP + 2);
        end
      end
      uart_frame(2, 6);
      fall_cyc = cyc;
    end
    req_valid = 4'h0;
  endtask

  task automatic test_timeout();
    bit ok;
    int s;
    apply_reset(2);
    tx_busy = 1'b0;
    set_byte(0, 8'h5A);
    req_valid = 4'b0001;
    wait_start(BUDGET, ok);
    s = cyc;
    total++;
    if (!ok || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL tmo_grant: got ok=%0d id=%0d want 1/0", ok, grant_id);
    end
    mdl_last = 0;
    req_valid = 4'b0000;
    set_byte(1, 8'hC3);
    req_valid = 4'b0010;
    wait_err(BUDGET, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL tmo_err_seen: got no tx_err want one"); end
    total++;
    if (cyc != s + TMO + 1) begin bad++; $display("FAIL tmo_err_time: got %0d want %0d", cyc - s, TMO + 1); end
    tick();
    total++;
    if (tx_err !== 1'b0) begin bad++; $display("FAIL tmo_err_width: got %b want 0", tx_err); end
    wait_start(BUDGET, ok);
    total++;
    if (!ok || cyc != s + TMO + GAP + 2) begin
      bad++;
      $display("FAIL tmo_next_start: got ok=%0d at %0d want 1 at %0d", ok, cyc - s, TMO + GAP + 2);
    end
    total++;
    if (grant_id !== 2'd1 || tx_data !== 8'hC3) begin
      bad++;
      $display("FAIL tmo_no_resend: got id=%0d data=%h want 1/c3", grant_id, tx_data);
    end
    req_valid = 4'h0;
    uart_frame(1, 3);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    int w;
    apply_reset(2);
    set_byte(2, 8'h77);
    req_valid = 4'b0100;
    wait_start(BUDGET, ok);
    total++;
    if (!ok || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL rmid_grant: got ok=%0d id=%0d want 1/2", ok, grant_id);
    end
    req_valid = 4'h0;
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_last = NUM_REQ - 1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tx_start !== 1'b0 || req_ready !== 4'h0) begin
        bad++;
        $display("FAIL rmid_quiet[%0d]: got start=%b ready=%b want 0/0000", i, tx_start, req_ready);
      end
      tick();
    end
    set_byte(0, 8'h10);
    set_byte(3, 8'h33);
    req_valid = 4'b1001;
    t = cyc;
    w = rr_pick(mdl_last, req_valid);
    wait_start(BUDGET, ok);
    total++;
    if (!ok || cyc - t != 1) begin
      bad++;
      $display("FAIL rmid_latency: got ok=%0d lat=%0d want 1/1", ok, cyc - t);
    end
    total++;
    if (grant_id !== 2'(w) || tx_data !== 8'h10) begin
      bad++;
      $display("FAIL rmid_priority: got id=%0d data=%h want %0d/10", grant_id, tx_data, w);
    end
    req_valid = 4'h0;
    tick();
    tick();
    tx_busy = 1'b0;
  endtask

  task automatic test_withdraw();
    bit ok;
    int r1_0;
    int sc;
    apply_reset(2);
    set_byte(1, 8'hA1);
    set_byte(3, 8'hD3);
    req_valid = 4'b1010;
    r1_0 = r1_cnt;
    wait_start(BUDGET, ok);
    total++;
    if (!ok || grant_id !== 2'(rr_pick(mdl_last, req_valid)) || tx_data !== 8'hA1) begin
      bad++;
      $display("FAIL wd_first: got ok=%0d id=%0d data=%h want 1/1/a1", ok, grant_id, tx_data);
    end
    mdl_last = 1;
    tick();
    req_valid = req_valid & 4'b1101;
    uart_frame(1, 4);
    wait_start(BUDGET, ok);
    sc = start_cnt;
    total++;
    if (!ok || grant_id !== 2'(rr_pick(mdl_last, req_valid)) || tx_data !== 8'hD3) begin
      bad++;
      $display("FAIL wd_second: got ok=%0d id=%0d data=%h want 1/3/d3", ok, grant_id, tx_data);
    end
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL wd_ready: got %b want 1000", req_ready); end
    mdl_last = 3;
    req_valid = 4'h0;
    uart_frame(2, 4);
    repeat (GAP + 10) tick();
    total++;
    if (r1_cnt - r1_0 != 1) begin bad++; $display("FAIL wd_dup_accept: got %0d want 1", r1_cnt - r1_0); end
    total++;
    if (start_cnt != sc + 1) begin bad++; $display("FAIL wd_extra_start: got %0d want %0d", start_cnt - sc, 1); end
  endtask

  task automatic test_random();
    bit ok;
    int w;
    int s;
    int e0;
    logic [7:0] exp_data;
    apply_reset(2);
    req_valid = 4'h0;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (((req_valid >> i) & 4'd1) == 4'd0 && $urandom_range(1, 0) == 1) begin
          set_byte(i, 8'($urandom));
          req_valid = req_valid | 4'(1 << i);
        end
      end
      if (req_valid == 4'h0) begin
        s = int'($urandom_range(NUM_REQ - 1, 0));
        set_byte(s, 8'($urandom));
        req_valid = 4'(1 << s);
      end
      w = rr_pick(mdl_last, req_valid);
      exp_data = get_byte(w);
      wait_start(BUDGET, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rnd_start[%0d]: got no tx_start want one", n); end
      total++;
      if (grant_id !== 2'(w) || tx_data !== exp_data || req_ready !== 4'(1 << w)) begin
        bad++;
        $display("FAIL rnd_grant[%0d]: got id=%0d data=%h ready=%b want %0d/%h/%b",
                 n, grant_id, tx_data, req_ready, w, exp_data, 4'(1 << w));
      end
      mdl_last = w;
      req_valid = req_valid & ~4'(1 << w);
      e0 = err_cnt;
      if ($urandom_range(3, 0) == 0) begin
        s = cyc;
        wait_err(BUDGET, ok);
        total++;
        if (!ok || cyc != s + TMO + 1) begin
          bad++;
          $display("FAIL rnd_tmo[%0d]: got ok=%0d at %0d want 1 at %0d", n, ok, cyc - s, TMO + 1);
        end
      end else begin
        uart_frame(int'($urandom_range(6, 1)), int'($urandom_range(8, 1)));
        total++;
        if (err_cnt != e0) begin bad++; $display("FAIL rnd_spurious_err[%0d]: got %0d want 0", n, err_cnt - e0); end
      end
    end
    req_valid = 4'h0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'h0;
    req_data  = 32'h0;
    tx_busy   = 1'b0;
    mdl_last  = NUM_REQ - 1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
